// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and width definitions for the ALU scheduler
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RES_W_DEF  = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_LLS  = 4'd7;
  localparam logic [3:0] OP_LRS  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;
  localparam logic [3:0] OP_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_CAPT = 3'd2,
    ST_ITER = 3'd3,
    ST_FIX  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

endpackage

// File: rtl/alu_scheduler_if.sv
// rtl/alu_scheduler_if.sv - request, ALU and response signal bundle for the scheduler
interface alu_scheduler_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
);

  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_opcode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_opcode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_opcode;
  logic [RES_W-1:0]  alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_error;
  logic              busy;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_id, rsp_result, rsp_error, busy
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_id, rsp_result, rsp_error, busy
  );

endinterface

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - iterative signed multiply / restoring divide on operand magnitudes
module iter_muldiv #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int ITERS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [RES_W-1:0]  result
);

  localparam int CNT_W = $clog2(ITERS);

  logic                running;
  logic                div_mode;
  logic                neg;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   m;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] mag_prod;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;

  // Magnitudes are unsigned, so the most negative operand still fits in DATA_W bits.
  assign mag_a = a[DATA_W-1] ? -a : a;
  assign mag_b = b[DATA_W-1] ? -b : b;

  // MUL: hi:lo is the partial product, multiplier bits shift out of lo.
  assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  // DIV: hi is the partial remainder, dividend bits shift out of lo and quotient bits in.
  assign shifted = {hi, lo[DATA_W-1]};
  assign diff    = shifted - {1'b0, m};

  // High during the last step; the following cycle holds the final magnitude.
  assign done = running && (cnt == CNT_W'(ITERS - 1));

  // Sign fix-up; the quotient is truncated to DATA_W bits then sign-extended.
  assign mag_prod = {hi, lo};
  assign prod     = neg ? -mag_prod : mag_prod;
  assign quot     = neg ? -lo : lo;
  assign result   = div_mode ? RES_W'({{DATA_W{quot[DATA_W-1]}}, quot}) : RES_W'(prod);

  // Load magnitudes on start, then one shift-add or restoring-subtract step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      running  <= 1'b0;
      div_mode <= 1'b0;
      neg      <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
    end else if (start) begin
      running  <= 1'b1;
      div_mode <= is_div;
      neg      <= a[DATA_W-1] ^ b[DATA_W-1];
      cnt      <= '0;
      hi       <= '0;
      lo       <= mag_a;
      m        <= mag_b;
    end else if (running) begin
      cnt <= cnt + CNT_W'(1);
      if (done) begin
        running <= 1'b0;
      end
      if (div_mode) begin
        hi <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        lo <= {lo[DATA_W-2:0], ~diff[DATA_W]};
      end else begin
        hi <= add_sum[DATA_W:1];
        lo <= {add_sum[0], lo[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin two-port sequencer for the shared ALU and MUL/DIV unit
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int ITERS  = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  alu_scheduler_if.slave bus
);

  state_e            state;
  logic              ptr;
  logic              idle;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              bad_op;
  logic              div_zero;
  logic              is_muldiv;
  logic              md_start;
  logic              md_done;
  logic [RES_W-1:0]  md_result;

  // ptr=0 favours req0 on a tie, ptr=1 favours req1; reset masks ready so it wins over a handshake.
  assign idle           = (state == ST_IDLE) && !reset;
  assign grant0         = bus.req0_valid && (!ptr || !bus.req1_valid);
  assign grant1         = bus.req1_valid && (ptr || !bus.req0_valid);
  assign bus.req0_ready = idle && grant0;
  assign bus.req1_ready = idle && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign sel            = bus.req1_ready;

  assign in_op     = sel ? bus.req1_opcode : bus.req0_opcode;
  assign in_a      = sel ? bus.req1_a : bus.req0_a;
  assign in_b      = sel ? bus.req1_b : bus.req0_b;
  assign bad_op    = in_op > OP_LAST;
  assign div_zero  = (in_op == OP_DIV) && (in_b == '0);
  assign is_muldiv = (in_op == OP_MUL) || (in_op == OP_DIV);
  assign md_start  = accept && is_muldiv && !div_zero;

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.busy      = (state != ST_IDLE);

  iter_muldiv #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .ITERS  (ITERS)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (in_op == OP_DIV),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );

  // Sequencer: accept and route in IDLE, then collect the result and hold it until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ptr            <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_error  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ptr            <= ~sel;
            bus.alu_a      <= in_a;
            bus.alu_b      <= in_b;
            bus.alu_opcode <= in_op;
            bus.rsp_id     <= sel;
            if (bad_op || div_zero) begin
              bus.rsp_result <= '0;
              bus.rsp_error  <= 1'b1;
              state          <= ST_RESP;
            end else if (is_muldiv) begin
              state <= ST_ITER;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: state <= ST_CAPT;
        ST_CAPT: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_error  <= 1'b0;
          state          <= ST_RESP;
        end
        ST_ITER: begin
          if (md_done) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          bus.rsp_result <= md_result;
          bus.rsp_error  <= 1'b0;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - self-checking bench for alu_scheduler with a behavioural reference
module tb_alu_scheduler;
  import alu_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   rand_rdy;
  bit   mptr;
  exp_t exp_q[$];
  int   grant_log[$];
  exp_t mon_e;
  logic [31:0] mon_r;
  logic mon_err;
  logic exp_r0;
  logic exp_r1;

  alu_scheduler_if bus ();

  alu_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // External ALU: signed operands, 32-bit result.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] sa;
    logic [31:0] sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    case (op)
      OP_ADD:  return sa + sb;
      OP_SUB:  return sa - sb;
      OP_AND:  return sa & sb;
      OP_OR:   return sa | sb;
      OP_XOR:  return sa ^ sb;
      OP_LLS:  return sa << b[3:0];
      OP_LRS:  return {16'h0, a} >> b[3:0];
      OP_INC:  return sa + 32'd1;
      OP_DEC:  return sa - 32'd1;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [31:0] r, output logic e);
    int ia;
    int ib;
    int q;
    ia = $signed(a);
    ib = $signed(b);
    r = 32'h0;
    e = 1'b0;
    if (op > OP_LAST) e = 1'b1;
    else if (op == OP_MUL) r = ia * ib;
    else if (op == OP_DIV) begin
      if (ib == 0) e = 1'b1;
      else begin
        q = ia / ib;
        r = {{16{q[15]}}, q[15:0]};
      end
    end else r = alu_fn(op, a, b);
  endfunction

  always @(posedge clk) bus.alu_result <= alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: arbitration rules, expected-result queue, in-order response scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mptr = 1'b0;
      check("ready0_in_reset", bus.req0_ready, 0);
      check("ready1_in_reset", bus.req1_ready, 0);
    end else begin
      exp_r0 = !bus.busy && bus.req0_valid && (!mptr || !bus.req1_valid);
      exp_r1 = !bus.busy && bus.req1_valid && (mptr || !bus.req0_valid);
      check("ready0", bus.req0_ready, exp_r0);
      check("ready1", bus.req1_ready, exp_r1);
      if (exp_r0 || exp_r1) begin
        if (exp_r1) ref_op(bus.req1_opcode, bus.req1_a, bus.req1_b, mon_r, mon_err);
        else        ref_op(bus.req0_opcode, bus.req0_a, bus.req0_b, mon_r, mon_err);
        mon_e.id  = exp_r1;
        mon_e.res = mon_r;
        mon_e.err = mon_err;
        exp_q.push_back(mon_e);
        grant_log.push_back(int'(exp_r1));
        mptr = !exp_r1;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("sb_id", bus.rsp_id, mon_e.id);
          check("sb_result", bus.rsp_result, mon_e.res);
          check("sb_error", bus.rsp_error, mon_e.err);
        end
      end
    end
  end

  task automatic set_req(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (port == 0) begin
      bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input int port);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready : bus.req1_ready) ok = 1;
    end
    check("accept_wait", ok, 1);
    @(posedge clk);
    #1;
    if (port == 0) bus.req0_valid = 1'b0;
    else           bus.req1_valid = 1'b0;
  endtask

  task automatic send(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    set_req(port, op, a, b);
    wait_accept(port);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) ok = 1;
    end
    check("drain", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [31:0] er, input logic ee);
    int n;
    bit busy_ok;
    bit seen;
    send(port, op, a, b);
    n = 0;
    busy_ok = 1;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (!bus.busy) busy_ok = 0;
      if (n == 1) begin
        check("alu_opcode", bus.alu_opcode, op);
        check("alu_a", bus.alu_a, a);
        check("alu_b", bus.alu_b, b);
      end
      if (bus.rsp_valid) seen = 1;
    end
    check("rsp_latency", n, lat);
    check("busy_during_op", busy_ok, 1);
    check("rsp_result", bus.rsp_result, er);
    check("rsp_error", bus.rsp_error, ee);
    check("rsp_id", bus.rsp_id, port);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_after_rsp", bus.busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_g[4];
    bit ok;
    checks = 0;
    errors = 0;
    rand_rdy = 0;
    mptr = 0;
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_opcode = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_opcode = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.alu_result = '0;

    // Reset state with a request already pending on req0.
    set_req(0, OP_ADD, -16'sd10, -16'sd11);
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_opcode", bus.alu_opcode, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_op(0, OP_ADD, -16'sd10, -16'sd11, 3, 32'hFFFF_FFEB, 1'b0);
    run_op(1, OP_MUL, -16'sd300, 16'sd7, 18, 32'hFFFF_F7CC, 1'b0);

    // Both ports contend; the pointer was left favouring req0.
    grant_log.delete();
    fork
      begin send(0, OP_XOR, 16'h1234, 16'h00FF); send(0, OP_XOR, 16'hAAAA, 16'h5555); end
      begin send(1, OP_SUB, 16'd100, 16'd300);   send(1, OP_SUB, 16'h8000, 16'd1);    end
    join
    drain();
    exp_g = '{0, 1, 0, 1};
    check("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check("grant_order", grant_log[i], exp_g[i]);
    end

    run_op(0, OP_DIV, 16'sd25, 16'sd5, 18, 32'h0000_0005, 1'b0);
    run_op(0, OP_DIV, -16'sd7, 16'sd2, 18, 32'hFFFF_FFFD, 1'b0);
    run_op(0, OP_DIV, 16'h8000, 16'hFFFF, 18, 32'hFFFF_8000, 1'b0);
    run_op(0, OP_DIV, 16'sd9, 16'sd0, 1, 32'h0, 1'b1);
    run_op(1, 4'b1101, 16'sd3, 16'sd4, 1, 32'h0, 1'b1);

    // Response back-pressure: result holds and nothing new is accepted.
    bus.rsp_ready = 1'b0;
    send(0, OP_ADD, 16'd1, 16'd2);
    set_req(1, OP_INC, 16'd5, 16'd0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1;
    end
    check("hold_rsp_seen", ok, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_result", bus.rsp_result, 32'd3);
      check("hold_id", bus.rsp_id, 0);
      check("hold_ready0", bus.req0_ready, 0);
      check("hold_ready1", bus.req1_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_accept(1);
    drain();

    // Reset during cycle 8 of a MUL; pointer returns to req0.
    send(0, OP_MUL, 16'd123, -16'sd45);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    grant_log.delete();
    set_req(0, OP_INC, 16'd45, 16'd0);
    set_req(1, OP_DEC, 16'd3, 16'd0);
    fork
      begin
        @(negedge clk);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_rsp_valid", bus.rsp_valid, 0);
        check("post_rst_ready0", bus.req0_ready, 1);
        check("post_rst_ready1", bus.req1_ready, 0);
      end
      wait_accept(0);
      wait_accept(1);
    join
    drain();
    check("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) check("post_rst_first", grant_log[0], 0);

    // Randomised traffic on both ports with random response back-pressure.
    rand_rdy = 1;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          logic [3:0] op; logic [15:0] a; logic [15:0] b;
          op = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL;
          a = 16'($urandom); b = 16'($urandom);
          if ($urandom_range(0, 7) == 0) a = 16'h8000;
          case ($urandom_range(0, 7))
            0: b = 16'h0;
            1: b = 16'hFFFF;
            2: b = {12'h0, b[3:0]};
            default: ;
          endcase
          send(0, op, a, b);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          logic [3:0] op; logic [15:0] a; logic [15:0] b;
          op = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL;
          a = 16'($urandom); b = 16'($urandom);
          if ($urandom_range(0, 7) == 0) b = 16'h0;
          send(1, op, a, b);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    rand_rdy = 0;
    bus.rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Two-port arbiter and sequencer for the shared 16-bit ALU. Accepts operations from two requesters through valid/ready handshakes, grants round-robin, and drives the ALU operand/opcode inputs for single-cycle ops. Executes MUL and DIV in an internal iterative unit rather than on the ALU. Returns one tagged result at a time through a valid/ready response port.

## Interface
- `DATA_W`, 16: operand width.
- `RES_W`, 32: result width.
- `ITERS`, 16: MUL/DIV iteration count; must equal `DATA_W`.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_opcode`, `req1_opcode`  in  4  operation code (shared package encoding).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DATA_W  signed operands.
- `alu_a`, `alu_b`  out  DATA_W  ALU operands.
- `alu_opcode`  out  4  ALU opcode.
- `alu_result`  in  RES_W  ALU registered result.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  1  requester index of the response.
- `rsp_result`  out  RES_W  signed result.
- `rsp_error`  out  1  illegal opcode or divide by zero.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Opcodes: ADD 0, SUB 1, MUL 2, DIV 3, AND 4, OR 5, XOR 6, LLS 7, LRS 8, INC 9, DEC 10. Codes 11–15 are illegal.
- FSM states: IDLE, EXEC, CAPT, ITER, FIX, RESP.
- IDLE: arbitrate among valid requests.
  - Only the granted port sees ready=1; ready is combinational from the valids and the round-robin pointer.
  - Transfer occurs when valid&ready. Latch opcode, a, b and id.
  - Pointer then prefers the other port. After reset, req0 has priority.
  - Requesters hold valid and payload stable until accepted.
- Routing from IDLE after acceptance:
  - ALU ops (0, 1, 4–10) go to EXEC.
  - MUL/DIV with nonzero divisor go to ITER; the iteration counter is cleared.
  - Illegal opcode, or DIV with b=0, goes directly to RESP with result 0 and error=1.
- EXEC: `alu_a`/`alu_b`/`alu_opcode` carry the latched values. They hold these values from acceptance until the next acceptance. Next state is CAPT.
- CAPT: sample `alu_result` into the response register. Next state is RESP.
- ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle on operand magnitudes. After ITERS cycles, go to FIX.
- FIX: apply the sign.
  - MUL: 32-bit signed product.
  - DIV: quotient truncated toward zero, sign-extended from 16 bits.
  - -32768 / -1 yields 32'hFFFF_8000 with error=0. Remainder is discarded.
- RESP: `rsp_valid` stays high, with `rsp_result`/`rsp_id`/`rsp_error` stable, until `rsp_ready`. On valid&ready go to IDLE. No request is accepted outside IDLE.
- Reset values:
  - State IDLE; pointer at req0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `rsp_error`=0.
  - `alu_a`/`alu_b`/`alu_opcode`=0; `busy`=0; both ready=0.
- Reset mid-operation: the in-flight op is discarded and no response is issued. Reset takes priority over any simultaneous handshake.

## Timing
- Edge numbering: acceptance edge E0.
- ALU op: EXEC after E0, CAPT after E1, `rsp_valid` high after E2.
- MUL/DIV: ITER after E0 through E15, FIX after E16, `rsp_valid` high after E17.
- Error path: `rsp_valid` high after E0.
- `rsp_ready` held high: return to IDLE on the edge after `rsp_valid` rises. The earliest next acceptance is the following edge, giving one dead cycle between responses.
- Both valids high in the same IDLE cycle: exactly one grant. The other port waits at least until the next IDLE.
- `rsp_ready` low: RESP holds indefinitely; no timeout.

## Structure
- Package `alu_pkg`:
  - opcode localparams OP_ADD…OP_DEC and OP_LAST=10;
  - state enum for the FSM;
  - DATA_W/RES_W defaults.
- Sub-module `iter_muldiv`:
  - inputs `start`, `is_div`, a, b;
  - outputs `done` pulse and a RES_W result;
  - internal counter, accumulator and sign/FIX logic.
- The top level holds the arbiter, FSM, latches and response register. The ALU itself stays outside and connects via the `alu_*` ports.

## Test plan
- Reset, then req0 ADD a=-10, b=-11 → accepted at E0; `alu_opcode`=0; `rsp_valid` after E2; result 32'hFFFF_FFEB; id 0; error 0.
- Both ports valid in consecutive IDLE windows: req0 XOR, req1 SUB, held high → grants alternate 0,1,0,1. Responses are returned in grant order with matching ids.
- req1 MUL a=-300, b=7 → `rsp_valid` exactly 17 cycles after acceptance; result -2100; `busy` high throughout.
- DIV 25/5 → 5. DIV -7/2 → -3. DIV -32768/-1 → 32'hFFFF_8000, error 0. DIV 9/0 → result 0, error 1, `rsp_valid` one edge after acceptance.
- Opcode 4'b1101 → result 0, error 1. `rsp_ready` held low 5 cycles → response stable, both ready low, no new acceptance.
- Reset asserted during cycle 8 of a MUL → next cycle IDLE, `rsp_valid` 0, pointer at req0. The following req0 INC 45 returns 46.
